// File: rtl/bus_cache_if.sv
// Pulse-request / ready bus used on both sides of bus_cache.
// The master drives address, write data and the request pulses; the slave answers.
interface bus_cache_if;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    logic [31:0] spo;
    logic        ready;

    modport master (output a, d, we, rd, input spo, ready);
    modport slave  (input a, d, we, rd, output spo, ready);
endinterface

// File: rtl/bus_cache.sv
// Direct-mapped, write-through, no-write-allocate unified cache, 4 words per line.
// Only addresses whose top nibble equals CACHED_TOP are cached; all else is forwarded.
module bus_cache #(
    parameter int unsigned INDEX_W    = 6,
    parameter logic [3:0]  CACHED_TOP = 4'h2
) (
    input logic         clk,
    input logic         rst,
    bus_cache_if.slave  cpu,
    bus_cache_if.master mem
);
    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_MREQ, S_MWAIT} state_t;
    typedef enum logic [1:0] {M_FWD_RD, M_FWD_WR, M_REFILL} mode_t;

    state_t r_state, w_state_nxt;
    mode_t  r_mode, w_mode_nxt;

    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [31:0]      r_resp;
    logic [1:0]       r_cnt;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];
    logic [31:0]      r_arr [4*LINES];

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_off;
    logic               w_cacheable;
    logic               w_hit;
    logic [INDEX_W-1:0] w_r_idx;
    logic               w_beat;
    logic               w_last;

    assign w_idx       = cpu.a[3+INDEX_W:4];
    assign w_tag       = cpu.a[31:4+INDEX_W];
    assign w_off       = cpu.a[3:2];
    assign w_cacheable = (cpu.a[31:28] == CACHED_TOP);
    assign w_hit       = w_cacheable && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_r_idx     = r_addr[3+INDEX_W:4];
    assign w_beat      = (r_state != S_IDLE) && mem.ready;
    assign w_last      = (r_mode != M_REFILL) || (r_cnt == 2'd3);

    // Downstream address/data come straight from the latched request so they hold through MWAIT.
    assign mem.a = (r_mode == M_REFILL) ? {r_addr[31:4], r_cnt, 2'b00} : r_addr;
    assign mem.d = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= M_FWD_RD;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        cpu.ready   = 1'b0;
        cpu.spo     = r_resp;
        mem.rd      = 1'b0;
        mem.we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cpu.ready = 1'b1;
                if (cpu.we) begin
                    cpu.ready   = 1'b0;
                    w_mode_nxt  = M_FWD_WR;
                    w_state_nxt = S_MREQ;
                end else if (cpu.rd) begin
                    if (w_hit) begin
                        cpu.spo = r_arr[{w_idx, w_off}];
                    end else begin
                        cpu.ready   = 1'b0;
                        w_mode_nxt  = w_cacheable ? M_REFILL : M_FWD_RD;
                        w_state_nxt = S_MREQ;
                    end
                end
            end
            S_MREQ: begin
                mem.rd = (r_mode != M_FWD_WR);
                mem.we = (r_mode == M_FWD_WR);
                if (!mem.ready)  w_state_nxt = S_MWAIT;
                else if (w_last) w_state_nxt = S_IDLE;
                else             w_state_nxt = S_MREQ;
            end
            S_MWAIT: begin
                if (mem.ready) w_state_nxt = w_last ? S_IDLE : S_MREQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_resp  <= '0;
            r_cnt   <= '0;
            r_valid <= '0;
        end else if (r_state == S_IDLE) begin
            if (cpu.we) begin
                r_addr <= cpu.a;
                r_data <= cpu.d;
            end else if (cpu.rd && !w_hit) begin
                r_addr <= cpu.a;
                r_cnt  <= '0;
                if (w_cacheable) r_valid[w_idx] <= 1'b0;
            end
        end else if (w_beat) begin
            if (r_mode == M_FWD_RD) r_resp <= mem.spo;
            if (r_mode == M_REFILL) begin
                if (r_cnt == r_addr[3:2]) r_resp <= mem.spo;
                if (r_cnt == 2'd3) r_valid[w_r_idx] <= 1'b1;
                else               r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    // Data and tag arrays carry no reset; a line is only trusted once its valid flop is set.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            if (cpu.we && w_hit) r_arr[{w_idx, w_off}] <= cpu.d;
        end else if (w_beat && r_mode == M_REFILL) begin
            r_arr[{w_r_idx, r_cnt}] <= mem.spo;
            if (r_cnt == 2'd3) r_tag[w_r_idx] <= r_addr[31:4+INDEX_W];
        end
    end
endmodule
